// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage and the display controller:
// opcodes, instruction field positions, default widths and sign extension.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 4;
  localparam int CPU_IMM_W  = 7;
  localparam int IMM11_W    = 11;
  localparam int INSTR_W    = 18;

  localparam int OPC_MSB = 17;
  localparam int OPC_LSB = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 3;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SUBI  = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_DPL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_NOTIFY = 2'd3
  } exec_state_e;

  function automatic logic [CPU_DATA_W-1:0] sext7(input logic [CPU_IMM_W-1:0] imm);
    return {{(CPU_DATA_W-CPU_IMM_W){imm[CPU_IMM_W-1]}}, imm};
  endfunction

  function automatic logic [CPU_DATA_W-1:0] sext11(input logic [IMM11_W-1:0] imm);
    return {{(CPU_DATA_W-IMM11_W){imm[IMM11_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_exec_unit_if.sv
// Instruction handshake from the input stage plus the display-controller
// side of the execute stage, bundled as one interface.
interface cpu_exec_unit_if #(
  parameter int DATA_W = cpu_pkg::CPU_DATA_W,
  parameter int REG_AW = cpu_pkg::CPU_REG_AW
) ();
  logic                        instr_valid;
  logic [cpu_pkg::INSTR_W-1:0] instr;
  logic                        instr_ready;
  logic                        lcd_ready;
  logic                        lcd_start;
  logic [2:0]                  lcd_opcode;
  logic [REG_AW-1:0]           lcd_reg_idx;
  logic [DATA_W-1:0]           lcd_value;
  logic                        ovf;
  logic                        busy;

  modport master (
    output instr_valid, instr, lcd_ready,
    input  instr_ready, lcd_start, lcd_opcode, lcd_reg_idx, lcd_value, ovf, busy
  );

  modport slave (
    input  instr_valid, instr, lcd_ready,
    output instr_ready, lcd_start, lcd_opcode, lcd_reg_idx, lcd_value, ovf, busy
  );
endinterface

// File: rtl/regfile_16x16.sv
// Register file: two combinational read ports, one synchronous write port,
// every entry cleared by the asynchronous reset.
module regfile_16x16 #(
  parameter int DATA_W = cpu_pkg::CPU_DATA_W,
  parameter int REG_AW = cpu_pkg::CPU_REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);
  localparam int N_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] w_mem [N_REGS];

  // Discrete flops rather than RAM: the whole file must zero on reset.
  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_q <= '0;
        end else if (i_we && (i_waddr == REG_AW'(gi))) begin
          r_q <= i_wdata;
        end
      end

      assign w_mem[gi] = r_q;
    end
  endgenerate

  assign o_rdata_a = w_mem[i_raddr_a];
  assign o_rdata_b = w_mem[i_raddr_b];
endmodule

// File: rtl/cpu_exec_unit.sv
// Single-issue execute stage: runs one instruction per handshake against the
// register file and hands {opcode, register, value} to the LCD controller.
module cpu_exec_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW,
  parameter int IMM_W  = CPU_IMM_W
) (
  input logic             clk,
  input logic             reset_n,
  cpu_exec_unit_if.slave  bus
);
  exec_state_e         r_state;
  logic [INSTR_W-1:0]  r_instr;
  logic [REG_AW-1:0]   r_clr_cnt;
  logic                r_instr_ready;
  logic                r_lcd_start;
  logic [2:0]          r_lcd_opcode;
  logic [REG_AW-1:0]   r_lcd_reg_idx;
  logic [DATA_W-1:0]   r_lcd_value;
  logic                r_ovf;

  logic [2:0]               w_opcode;
  logic [REG_AW-1:0]        w_rd;
  logic [REG_AW-1:0]        w_rs1;
  logic [REG_AW-1:0]        w_rs2;
  logic [DATA_W-1:0]        w_rdata_a;
  logic [DATA_W-1:0]        w_rdata_b;
  logic signed [DATA_W-1:0] w_op_a;
  logic signed [DATA_W-1:0] w_op_b;
  logic signed [DATA_W-1:0] w_imm7;
  logic signed [DATA_W-1:0] w_imm11;
  logic signed [DATA_W-1:0] w_addend;
  logic signed [DATA_W-1:0] w_subtrahend;
  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_diff;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [DATA_W-1:0] w_result;
  logic                     w_ovf_calc;
  logic                     w_we;
  logic [REG_AW-1:0]        w_waddr;
  logic [DATA_W-1:0]        w_wdata;

  assign w_opcode = r_instr[OPC_MSB:OPC_LSB];
  assign w_rd     = r_instr[RD_MSB:RD_LSB];
  assign w_rs1    = r_instr[RS1_MSB:RS1_LSB];
  assign w_rs2    = r_instr[RS2_MSB:RS2_LSB];

  assign w_op_a       = w_rdata_a;
  assign w_op_b       = w_rdata_b;
  assign w_imm7       = sext7(r_instr[IMM_W-1:0]);
  assign w_imm11      = sext11(r_instr[IMM11_W-1:0]);
  assign w_addend     = (w_opcode == OP_ADDI) ? w_imm7 : w_op_b;
  assign w_subtrahend = (w_opcode == OP_SUBI) ? w_imm7 : w_op_b;
  assign w_sum        = w_op_a + w_addend;
  assign w_diff       = w_op_a - w_subtrahend;
  assign w_prod       = w_op_a * w_op_b;

  // Overflow from sign bits: operands agree (add) / differ (sub) and the result flips.
  always_comb begin
    w_result   = '0;
    w_ovf_calc = 1'b0;
    case (w_opcode)
      OP_LOAD: w_result = w_imm11;
      OP_ADD, OP_ADDI: begin
        w_result   = w_sum;
        w_ovf_calc = (w_op_a[DATA_W-1] == w_addend[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != w_op_a[DATA_W-1]);
      end
      OP_SUB, OP_SUBI: begin
        w_result   = w_diff;
        w_ovf_calc = (w_op_a[DATA_W-1] != w_subtrahend[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != w_op_a[DATA_W-1]);
      end
      OP_MUL: begin
        w_result   = w_prod[DATA_W-1:0];
        w_ovf_calc = (w_prod[2*DATA_W-1:DATA_W-1] != '0) &&
                     (w_prod[2*DATA_W-1:DATA_W-1] != '1);
      end
      OP_DPL:  w_result = w_op_a;
      default: w_result = '0;
    endcase
  end

  // The clear sequencer borrows the single write port from EXEC.
  assign w_we    = ((r_state == ST_EXEC) && (w_opcode != OP_DPL)) || (r_state == ST_CLEAR);
  assign w_waddr = (r_state == ST_CLEAR) ? r_clr_cnt : w_rd;
  assign w_wdata = (r_state == ST_CLEAR) ? '0 : w_result;

  regfile_16x16 #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rs1),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_rs2),
    .o_rdata_b (w_rdata_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_clr_cnt     <= '0;
      r_instr_ready <= 1'b0;
      r_lcd_start   <= 1'b0;
      r_lcd_opcode  <= '0;
      r_lcd_reg_idx <= '0;
      r_lcd_value   <= '0;
      r_ovf         <= 1'b0;
    end else begin
      r_lcd_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Ready rises one cycle after lcd_start, so acceptance never coincides with it.
          if (r_instr_ready && bus.instr_valid) begin
            r_instr       <= bus.instr;
            r_instr_ready <= 1'b0;
            r_clr_cnt     <= '0;
            r_state       <= (bus.instr[OPC_MSB:OPC_LSB] == OP_CLEAR) ? ST_CLEAR : ST_EXEC;
          end else begin
            r_instr_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_lcd_opcode  <= w_opcode;
          r_lcd_reg_idx <= (w_opcode == OP_DPL) ? w_rs1 : w_rd;
          r_lcd_value   <= w_result;
          r_ovf         <= w_ovf_calc;
          r_state       <= ST_NOTIFY;
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + REG_AW'(1);
          if (&r_clr_cnt) begin
            r_lcd_opcode  <= OP_CLEAR;
            r_lcd_reg_idx <= '0;
            r_lcd_value   <= '0;
            r_ovf         <= 1'b0;
            r_state       <= ST_NOTIFY;
          end
        end
        ST_NOTIFY: begin
          if (bus.lcd_ready) begin
            r_lcd_start <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.busy        = ~r_instr_ready;
  assign bus.lcd_start   = r_lcd_start;
  assign bus.lcd_opcode  = r_lcd_opcode;
  assign bus.lcd_reg_idx = r_lcd_reg_idx;
  assign bus.lcd_value   = r_lcd_value;
  assign bus.ovf         = r_ovf;
endmodule

// File: tb/tb_cpu_exec_unit.sv
// Scoreboard bench for cpu_exec_unit: an integer reference model predicts each
// display transaction at acceptance; a monitor checks every lcd_start pulse.
module tb_cpu_exec_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  idx;
    logic [15:0] val;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset_n;
  cpu_exec_unit_if bus ();

  cpu_exec_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  exp_t exp_q[$];
  int   m_regs[16];
  bit   lcd_rand  = 0;
  bit   lcd_force = 1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  function automatic int wrap16(input longint v);
    longint w;
    w = v % 65536;
    if (w < 0) w += 65536;
    if (w > 32767) w -= 65536;
    return int'(w);
  endfunction

  // Reference model: plain integer arithmetic, range test for overflow.
  function automatic exp_t model(input logic [17:0] ins);
    exp_t   e;
    int     op, rd, rs1, rs2;
    longint a, b, i7, i11, full;
    logic signed [6:0]  s7;
    logic signed [10:0] s11;
    op  = int'(ins[17:15]);
    rd  = int'(ins[14:11]);
    rs1 = int'(ins[10:7]);
    rs2 = int'(ins[6:3]);
    s7  = ins[6:0];
    s11 = ins[10:0];
    i7  = longint'(s7);
    i11 = longint'(s11);
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    e.op = 3'(op);
    e.idx = 4'(rd);
    e.ovf = 1'b0;
    full = 0;
    case (op)
      0: full = i11;
      1: full = a + b;
      2: full = a + i7;
      3: full = a - b;
      4: full = a - i7;
      5: full = a * b;
      default: full = 0;
    endcase
    if (op == 6) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      e.idx = 4'd0;
      e.val = 16'd0;
    end else if (op == 7) begin
      e.idx = 4'(rs1);
      e.val = 16'(m_regs[rs1]);
    end else begin
      e.ovf = (op != 0) && (full > 32767 || full < -32768);
      m_regs[rd] = wrap16(full);
      e.val = 16'(m_regs[rd]);
    end
    return e;
  endfunction

  task automatic issue(input logic [17:0] ins);
    bit ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check(0, "accept_timeout", "instr_ready low", "instr_ready high");
      return;
    end
    bus.instr = ins;
    bus.instr_valid = 1;
    @(posedge clk);
    exp_q.push_back(model(ins));
    #1 bus.instr_valid = 0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check(0, "drain_timeout", $sformatf("%0d pending", exp_q.size()), "0 pending");
  endtask

  function automatic logic [17:0] enc_r(input logic [2:0] op, input int rd, input int rs1, input int rs2);
    return {op, 4'(rd), 4'(rs1), 4'(rs2), 3'b000};
  endfunction

  function automatic logic [17:0] enc_i(input logic [2:0] op, input int rd, input int rs1, input int imm);
    return {op, 4'(rd), 4'(rs1), 7'(imm)};
  endfunction

  function automatic logic [17:0] enc_l(input int rd, input int imm);
    return {OP_LOAD, 4'(rd), 11'(imm)};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      bus.lcd_ready = lcd_rand ? ($urandom_range(0, 2) != 0) : lcd_force;
    end
  end

  // Monitor: every lcd_start pulse must match the oldest expectation.
  initial begin
    exp_t e;
    bit   prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.lcd_start) begin
        pulses++;
        if (prev) check(0, "double_start", "lcd_start high twice", "single-cycle pulse");
        if (exp_q.size() == 0) begin
          check(0, "unexpected_start", $sformatf("op=%0d idx=%0d", bus.lcd_opcode, bus.lcd_reg_idx),
                "no pulse");
        end else begin
          e = exp_q.pop_front();
          $display("txn op=%0d idx=%0d val=%0d ovf=%0d", bus.lcd_opcode, bus.lcd_reg_idx,
                   $signed(bus.lcd_value), bus.ovf);
          check(bus.lcd_opcode == e.op && bus.lcd_reg_idx == e.idx &&
                bus.lcd_value == e.val && bus.ovf == e.ovf, "lcd_txn",
                $sformatf("(%0d,%0d,%0d,ovf=%0d)", bus.lcd_opcode, bus.lcd_reg_idx,
                          $signed(bus.lcd_value), bus.ovf),
                $sformatf("(%0d,%0d,%0d,ovf=%0d)", e.op, e.idx, $signed(e.val), e.ovf));
        end
      end
      prev = bus.lcd_start;
    end
  end

  initial begin
    int          k;
    int          p0;
    bit          ok;
    logic [2:0]  s_op;
    logic [3:0]  s_idx;
    logic [15:0] s_val;
    logic [2:0]  op;
    logic [17:0] ins;

    reset_n = 0;
    bus.instr_valid = 0;
    bus.instr = '0;
    foreach (m_regs[i]) m_regs[i] = 0;
    repeat (3) @(negedge clk);
    check(bus.instr_ready == 0 && bus.lcd_start == 0 && bus.lcd_opcode == 0 &&
          bus.lcd_reg_idx == 0 && bus.lcd_value == 0 && bus.ovf == 0, "reset_state",
          $sformatf("rdy=%0d st=%0d val=%0d ovf=%0d", bus.instr_ready, bus.lcd_start,
                    bus.lcd_value, bus.ovf), "all 0");
    reset_n = 1;
    repeat (2) @(negedge clk);
    check(bus.instr_ready == 1 && bus.busy == 0, "idle_ready",
          $sformatf("rdy=%0d busy=%0d", bus.instr_ready, bus.busy), "rdy=1 busy=0");

    // Basic LOAD/ADD.
    issue(enc_l(2, 100));
    issue(enc_l(3, -5));
    issue(enc_r(OP_ADD, 4, 2, 3));
    wait_drain();
    check($signed(bus.lcd_value) == 95 && bus.ovf == 0, "add_result",
          $sformatf("%0d ovf=%0d", $signed(bus.lcd_value), bus.ovf), "95 ovf=0");

    // MUL overflow.
    issue(enc_l(1, 1000));
    issue(enc_r(OP_MUL, 5, 1, 1));
    wait_drain();
    check($signed(bus.lcd_value) == 16960 && bus.ovf == 1, "mul_result",
          $sformatf("%0d ovf=%0d", $signed(bus.lcd_value), bus.ovf), "16960 ovf=1");

    // SUBI to -128 in place.
    issue(enc_l(6, -65));
    issue(enc_i(OP_SUBI, 6, 6, 63));
    wait_drain();
    check(bus.lcd_opcode == OP_SUBI && bus.lcd_reg_idx == 6 && $signed(bus.lcd_value) == -128,
          "subi_result", $sformatf("(%0d,%0d,%0d)", bus.lcd_opcode, bus.lcd_reg_idx,
                                   $signed(bus.lcd_value)), "(4,6,-128)");

    // Doubling R7 from 1023 wraps on the sixth ADD.
    issue(enc_l(7, 1023));
    for (int i = 0; i < 6; i++) begin
      issue(enc_r(OP_ADD, 7, 7, 7));
      wait_drain();
      check(bus.ovf == (i == 5), $sformatf("double_ovf_%0d", i),
            $sformatf("%0d", bus.ovf), $sformatf("%0d", i == 5));
    end

    // CLEAR after filling every register.
    for (int r = 0; r < 16; r++) issue(enc_l(r, r * 7 + 1));
    wait_drain();
    issue(enc_r(OP_CLEAR, 0, 0, 0));
    ok = 1;
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.lcd_start) begin
        k = n;
        break;
      end
      if (!bus.busy) ok = 0;
    end
    check(k >= 18 && ok, "clear_latency", $sformatf("start at negedge %0d busy_ok=%0d", k, ok),
          "start no earlier than 17 cycles, busy throughout");
    check(bus.lcd_opcode == OP_CLEAR && bus.lcd_reg_idx == 0 && bus.lcd_value == 0,
          "clear_lcd", $sformatf("(%0d,%0d,%0d)", bus.lcd_opcode, bus.lcd_reg_idx,
                                 $signed(bus.lcd_value)), "(6,0,0)");
    issue(enc_r(OP_DPL, 0, 9, 0));
    wait_drain();
    check(bus.lcd_opcode == OP_DPL && bus.lcd_reg_idx == 9 && bus.lcd_value == 0, "dpl_after_clear",
          $sformatf("(%0d,%0d,%0d)", bus.lcd_opcode, bus.lcd_reg_idx, $signed(bus.lcd_value)),
          "(7,9,0)");

    // Display back-pressure: 500 cycles of lcd_ready=0, junk instr_valid ignored.
    issue(enc_l(2, 100));
    issue(enc_l(3, -5));
    wait_drain();
    lcd_force = 0;
    issue(enc_r(OP_ADD, 4, 2, 3));
    repeat (3) @(negedge clk);
    s_op = bus.lcd_opcode;
    s_idx = bus.lcd_reg_idx;
    s_val = bus.lcd_value;
    ok = 1;
    for (int n = 0; n < 500; n++) begin
      if (n < 5) begin
        bus.instr = enc_l(8, 77);
        bus.instr_valid = 1;
      end else begin
        bus.instr_valid = 0;
      end
      @(negedge clk);
      if (bus.lcd_start || bus.instr_ready || bus.lcd_opcode != s_op ||
          bus.lcd_reg_idx != s_idx || bus.lcd_value != s_val) ok = 0;
    end
    check(ok && s_val == 16'd95, "stall_hold", $sformatf("stable=%0d val=%0d", ok, $signed(s_val)),
          "stable=1 val=95");
    lcd_force = 1;
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.lcd_start) begin
        k = n;
        break;
      end
    end
    check(k != 0 && bus.instr_ready == 0, "stall_release",
          $sformatf("k=%0d rdy=%0d", k, bus.instr_ready), "pulse seen, rdy=0");
    @(negedge clk);
    check(bus.instr_ready == 1 && bus.lcd_start == 0, "ready_after_start",
          $sformatf("rdy=%0d st=%0d", bus.instr_ready, bus.lcd_start), "rdy=1 st=0");
    wait_drain();

    // Reset in the middle of CLEAR.
    for (int r = 0; r < 16; r++) issue(enc_l(r, -(r + 3)));
    issue(enc_r(OP_MUL, 0, 15, 14));
    wait_drain();
    issue(enc_r(OP_CLEAR, 0, 0, 0));
    repeat (7) @(posedge clk);
    #2 reset_n = 0;
    #1;
    check(bus.instr_ready == 0 && bus.lcd_start == 0 && bus.lcd_opcode == 0 &&
          bus.lcd_reg_idx == 0 && bus.lcd_value == 0 && bus.ovf == 0, "reset_mid_clear",
          $sformatf("rdy=%0d st=%0d op=%0d val=%0d ovf=%0d", bus.instr_ready, bus.lcd_start,
                    bus.lcd_opcode, bus.lcd_value, bus.ovf), "all 0");
    exp_q.delete();
    foreach (m_regs[i]) m_regs[i] = 0;
    p0 = pulses;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (20) @(negedge clk);
    check(pulses == p0, "no_start_after_reset", $sformatf("%0d pulses", pulses - p0), "0 pulses");
    for (int r = 0; r < 16; r++) issue(enc_r(OP_DPL, 0, r, 0));
    wait_drain();

    // Randomised traffic with random display back-pressure.
    lcd_rand = 1;
    for (int n = 0; n < 250; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_CLEAR && $urandom_range(0, 3) != 0) op = OP_MUL;
      ins = 18'($urandom);
      ins[17:15] = op;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ins);
    end
    wait_drain();
    lcd_rand = 0;
    lcd_force = 1;
    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_empty", $sformatf("%0d", exp_q.size()), "0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
